ok_wb_cmd_engine: RTL and testbench
===================================

# ok_wb_cmd_engine

Wishbone-side packet engine that sits directly downstream of the FrontPanel-to-Wishbone FIFO bridge in the `clk_i` domain. It pops 16-bit words from the bridge's inbound FIFO and decodes them into register read/write packets, then executes those packets on a 32-bit register bus. It returns read data, and optionally write acknowledgements, by pushing 16-bit words into the bridge's outbound FIFO for the host pipe-out.

## Interface
- `ACK_TIMEOUT`, default 255: cycles to wait for `reg_ack_i` before abandoning a register access (1..65535).
- `clk_i` in 1: single clock for the whole block.
- `rst_i` in 1: reset, synchronous and active-high.
- `bus_stb_o` in bridge terms out 1: strobe to the bridge; pops a word when `bus_we_o`=0, pushes a word when `bus_we_o`=1.
- `bus_we_o` out 1: 1 = push response word, 0 = pop command word.
- `bus_adr_o` out 8: tied to 8'h00.
- `bus_dat_o` out 32: {16'h0000, response word}.
- `bus_dat_i` in 32: bridge read data; [16] = inbound FIFO non-empty, [15:0] = popped word.
- `reg_adr_o` out 8: register address.
- `reg_dat_o` out 32: register write data.
- `reg_stb_o` out 1: register access request; held until ack or timeout.
- `reg_we_o` out 1: 1 = write, 0 = read; valid while `reg_stb_o`=1.
- `reg_dat_i` in 32: register read data; sampled on `reg_ack_i`.
- `reg_ack_i` in 1: single-cycle access completion.
- `busy_o` out 1: high whenever the FSM is not in IDLE.
- `err_o` out 1: sticky error flag; cleared only by reset.

## Operation
- Header word: [15:14] opcode (2'b01 write, 2'b10 read; 00/11 illegal), [13:8] count−1 (1..64 registers), [7:0] base address.
- Write packet: the header is followed by 2×N words, low half first, then high half, per register. Each register is written as {hi,lo} at the current address.
- Read packet: header only. The response is the header echoed unchanged, then 2×N words, low half then high half, per register.
- The address increments by 1 per register and wraps 8'hFF→8'h00 modulo 256; the count is unaffected.
- Illegal opcode: the header is discarded, `err_o` is set, no response is sent, and the FSM returns to IDLE.
- Timeout: `reg_stb_o` is dropped after `ACK_TIMEOUT` cycles without ack, and `err_o` is set. For a read, the data is replaced by 32'hDEAD_BEEF. For a write, the register is skipped. The packet continues either way.
- FSM states: IDLE → FETCH_HDR → DECODE → (write path) FETCH_LO → FETCH_HI → REG_ACC → back to FETCH_LO or IDLE; (read path) TX_HDR → REG_ACC → TX_LO → TX_HI → back to REG_ACC or IDLE.
- A FETCH state consists of a pop cycle followed by a capture cycle.
- Pushes are unconditional. The bridge exposes no outbound-full flag, so the host must drain pipe-out; words written while that FIFO is full are lost.

## Timing
- Reset values:
  - `bus_stb_o`, `bus_we_o`, `reg_stb_o`, `reg_we_o`, `busy_o`, `err_o` = 0.
  - `bus_dat_o`, `reg_dat_o` = 0; `reg_adr_o` = 8'h00.
  - FSM = IDLE.
- Pop: in cycle T, `bus_dat_i[16]`=1 is sampled in a FETCH state, and `bus_stb_o`=1 with `bus_we_o`=0 for exactly one cycle. `bus_dat_i[15:0]` is captured at T+1.
- The non-empty flag is not re-sampled before T+2, so there is at most one pop per 2 cycles. While the flag is 0, the FSM waits indefinitely.
- Push: `bus_stb_o`=1 with `bus_we_o`=1 for exactly one cycle per word; back-to-back pushes are allowed.
- Register access: `reg_stb_o` rises the cycle after entering REG_ACC and falls the cycle after `reg_ack_i`. An ack arriving in the same cycle the timeout expires counts as ack.
- Read latency from last header pop to echo push: 3 cycles.
- `rst_i` mid-packet abandons the packet immediately; all strobes drop on the next edge. Inbound words of a partial packet are not resynchronised: the next popped word is treated as a header.

## Configuration
- `OKWB_WRITE_ACK_EN` defined: each write packet, after its last register access, pushes one acknowledgement word equal to {2'b11, count−1, base address}. A write timeout during the packet forces ack bits [15:14]=2'b00.
- `OKWB_WRITE_ACK_EN` undefined: write packets produce no outbound traffic, and the ack logic is absent.

## Test plan
- Write, 1 register: words 16'h4010, 16'h5678, 16'h1234 → a single write of reg addr 8'h10 data 32'h12345678; `err_o`=0.
- Read burst with wrap: 16'h82FE with reg model returning addr×3 → pushes 16'h82FE then {0x02FA,0x0000}, {0x02FD,0x0000}, {0x0000,0x0000} for addresses FE, FF, 00.
- Slow/absent ack: read 16'h8005 with no `reg_ack_i` → ack wait lasts `ACK_TIMEOUT` cycles; pushes 16'h8005, 16'hBEEF, 16'hDEAD; `err_o`=1.
- Illegal opcode 16'hC0AA followed by 16'h8001 → no response to the first; second answered normally; `err_o`=1.
- Starved inbound: header popped, non-empty flag held 0 for 100 cycles before data → no extra pops, `busy_o`=1 throughout, write completes correctly. With `OKWB_WRITE_ACK_EN`, an ack word is pushed.
- Reset after the first data word of a write → strobes low next cycle, FSM IDLE, no register write issued, `err_o`=0.

Source files
------------

// File: rtl/ok_wb_cmd_engine.sv
// ok_wb_cmd_engine: pops 16-bit command words from the FrontPanel/Wishbone
// bridge, executes register read/write packets on a 32-bit register bus and
// pushes read data (and optionally write acknowledgements) back to the bridge.
// Optional feature macro: OKWB_WRITE_ACK_EN (one ack word per write packet).
module ok_wb_cmd_engine #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [7:0]  bus_adr_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  output logic [7:0]  reg_adr_o,
  output logic [31:0] reg_dat_o,
  output logic        reg_stb_o,
  output logic        reg_we_o,
  input  logic [31:0] reg_dat_i,
  input  logic        reg_ack_i,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [3:0] {
    IDLE, FETCH_HDR, DECODE, FETCH_LO, FETCH_HI, REG_ACC, TX_HDR, TX_LO, TX_HI
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);

  state_t      state;
  logic [1:0]  phase;
  logic [15:0] word_q;
  logic [15:0] lo_q;
  logic [15:0] hi_q;
  logic [15:0] resp_q;
  logic [5:0]  cnt_q;
  logic [15:0] timer_q;
  logic        is_wr_q;
`ifdef OKWB_WRITE_ACK_EN
  logic [13:0] hdr_q;
  logic        wr_to_q;
`endif

  logic unused_bus_hi;
  assign unused_bus_hi = &{1'b0, bus_dat_i[31:17]};

  assign bus_adr_o = 8'h00;
  assign bus_dat_o = {16'h0000, resp_q};
  assign busy_o    = (state != IDLE);

  // Packet sequencer: fetch phases are 0 = wait for data, 1 = pop, 2 = capture;
  // register access phases are 0 = raise strobe, 1 = wait for ack or timeout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      phase     <= 2'd0;
      bus_stb_o <= 1'b0;
      bus_we_o  <= 1'b0;
      reg_stb_o <= 1'b0;
      reg_we_o  <= 1'b0;
      reg_adr_o <= 8'h00;
      reg_dat_o <= 32'h0;
      err_o     <= 1'b0;
      word_q    <= 16'h0;
      lo_q      <= 16'h0;
      hi_q      <= 16'h0;
      resp_q    <= 16'h0;
      cnt_q     <= 6'd0;
      timer_q   <= 16'h0;
      is_wr_q   <= 1'b0;
`ifdef OKWB_WRITE_ACK_EN
      hdr_q     <= 14'h0;
      wr_to_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus_stb_o <= 1'b0;
          phase     <= 2'd0;
          if (bus_dat_i[16]) state <= FETCH_HDR;
        end

        FETCH_HDR, FETCH_LO, FETCH_HI: begin
          case (phase)
            2'd0: begin
              if (bus_dat_i[16]) begin
                bus_stb_o <= 1'b1;
                bus_we_o  <= 1'b0;
                phase     <= 2'd1;
              end
            end
            2'd1: begin
              bus_stb_o <= 1'b0;
              word_q    <= bus_dat_i[15:0];
              phase     <= 2'd2;
            end
            default: begin
              phase <= 2'd0;
              if (state == FETCH_HDR) begin
                state <= DECODE;
              end else if (state == FETCH_LO) begin
                lo_q  <= word_q;
                state <= FETCH_HI;
              end else begin
                state <= REG_ACC;
              end
            end
          endcase
        end

        DECODE: begin
          cnt_q     <= word_q[13:8];
          reg_adr_o <= word_q[7:0];
          phase     <= 2'd0;
          case (word_q[15:14])
            2'b01: begin
              is_wr_q <= 1'b1;
              state   <= FETCH_LO;
`ifdef OKWB_WRITE_ACK_EN
              hdr_q   <= word_q[13:0];
              wr_to_q <= 1'b0;
`endif
            end
            2'b10: begin
              is_wr_q   <= 1'b0;
              resp_q    <= word_q;
              bus_stb_o <= 1'b1;
              bus_we_o  <= 1'b1;
              state     <= TX_HDR;
            end
            default: begin
              err_o <= 1'b1;
              state <= IDLE;
            end
          endcase
        end

        TX_HDR: begin
          bus_stb_o <= 1'b0;
          phase     <= 2'd0;
          state     <= REG_ACC;
        end

        REG_ACC: begin
          if (phase == 2'd0) begin
            reg_stb_o <= 1'b1;
            reg_we_o  <= is_wr_q;
            if (is_wr_q) reg_dat_o <= {word_q, lo_q};
            timer_q   <= 16'h0;
            phase     <= 2'd1;
          end else if (reg_ack_i || (timer_q == TIMEOUT_LAST)) begin
            reg_stb_o <= 1'b0;
            phase     <= 2'd0;
            if (!reg_ack_i) err_o <= 1'b1;
            if (is_wr_q) begin
              reg_adr_o <= reg_adr_o + 8'd1;
`ifdef OKWB_WRITE_ACK_EN
              if (!reg_ack_i) wr_to_q <= 1'b1;
`endif
              if (cnt_q == 6'd0) begin
                state <= IDLE;
`ifdef OKWB_WRITE_ACK_EN
                resp_q    <= {(wr_to_q || !reg_ack_i) ? 2'b00 : 2'b11, hdr_q};
                bus_stb_o <= 1'b1;
                bus_we_o  <= 1'b1;
`endif
              end else begin
                cnt_q <= cnt_q - 6'd1;
                state <= FETCH_LO;
              end
            end else begin
              resp_q    <= reg_ack_i ? reg_dat_i[15:0] : 16'hBEEF;
              hi_q      <= reg_ack_i ? reg_dat_i[31:16] : 16'hDEAD;
              bus_stb_o <= 1'b1;
              bus_we_o  <= 1'b1;
              state     <= TX_LO;
            end
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end

        TX_LO: begin
          resp_q <= hi_q;
          state  <= TX_HI;
        end

        TX_HI: begin
          bus_stb_o <= 1'b0;
          reg_adr_o <= reg_adr_o + 8'd1;
          phase     <= 2'd0;
          if (cnt_q == 6'd0) begin
            state <= IDLE;
          end else begin
            cnt_q <= cnt_q - 6'd1;
            state <= REG_ACC;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ok_wb_cmd_engine.sv
// Directed testbench for ok_wb_cmd_engine: models the bridge FIFOs and a
// register slave returning addr*3, and checks packets against hand-computed words.
`timescale 1ns/1ps
module tb_ok_wb_cmd_engine;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        bus_stb_o, bus_we_o;
  logic [7:0]  bus_adr_o;
  logic [31:0] bus_dat_o;
  logic [31:0] bus_dat_i = 32'h0;
  logic [7:0]  reg_adr_o;
  logic [31:0] reg_dat_o;
  logic        reg_stb_o, reg_we_o;
  logic [31:0] reg_dat_i = 32'h0;
  logic        reg_ack_i = 1'b0;
  logic        busy_o, err_o;

  logic [15:0] in_q[$];
  logic [15:0] out_q[$];
  int          out_cyc[$];
  logic [39:0] wr_log[$];
  int          cyc = 0;
  int          pop_cnt = 0;
  int          last_pop_cyc = 0;
  int          stb_cycles = 0;
  logic        ack_en = 1'b1;
  int          tests = 0;
  int          failed = 0;

  ok_wb_cmd_engine #(.ACK_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o),
    .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i),
    .reg_adr_o(reg_adr_o), .reg_dat_o(reg_dat_o), .reg_stb_o(reg_stb_o),
    .reg_we_o(reg_we_o), .reg_dat_i(reg_dat_i), .reg_ack_i(reg_ack_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Bridge and register-slave models: pop/push/write logging on the active edge.
  always @(posedge clk) begin
    cyc++;
    if (bus_stb_o && !bus_we_o && in_q.size() != 0) begin
      void'(in_q.pop_front());
      pop_cnt++;
      last_pop_cyc = cyc;
    end
    if (bus_stb_o && bus_we_o) begin
      out_q.push_back(bus_dat_o[15:0]);
      out_cyc.push_back(cyc);
    end
    if (reg_stb_o) stb_cycles++;
    if (reg_stb_o && reg_ack_i && reg_we_o) wr_log.push_back({reg_adr_o, reg_dat_o});
  end

  // Inputs change on the falling edge: FIFO head/flag and a one-cycle slave ack.
  always @(negedge clk) begin
    bus_dat_i = {15'h0, in_q.size() != 0, (in_q.size() != 0) ? in_q[0] : 16'h0};
    if (reg_ack_i) begin
      reg_ack_i = 1'b0;
    end else if (reg_stb_o && ack_en) begin
      reg_ack_i = 1'b1;
      reg_dat_i = 32'(reg_adr_o) * 32'd3;
    end
  end

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    in_q.delete(); out_q.delete(); out_cyc.delete(); wr_log.delete();
    pop_cnt = 0; stb_cycles = 0; ack_en = 1'b1;
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if ({bus_stb_o, bus_we_o, reg_stb_o, reg_we_o} !== 4'b0000) begin
      failed++; $display("[TB] FAIL reset_strobes got %b want 0000", {bus_stb_o, bus_we_o, reg_stb_o, reg_we_o}); end
    tests++; if ({busy_o, err_o} !== 2'b00) begin
      failed++; $display("[TB] FAIL reset_flags got %b want 00", {busy_o, err_o}); end
    tests++; if (bus_dat_o !== 32'h0) begin
      failed++; $display("[TB] FAIL reset_bus_dat got %h want 0", bus_dat_o); end
    tests++; if (reg_dat_o !== 32'h0 || reg_adr_o !== 8'h00) begin
      failed++; $display("[TB] FAIL reset_reg got %h/%h want 00/0", reg_adr_o, reg_dat_o); end
    tests++; if (bus_adr_o !== 8'h00) begin
      failed++; $display("[TB] FAIL reset_bus_adr got %h want 00", bus_adr_o); end
    do_reset();
  endtask

  task automatic test_write_single();
    int k = 0;
    do_reset();
    in_q.push_back(16'h4010); in_q.push_back(16'h5678); in_q.push_back(16'h1234);
    while (wr_log.size() < 1 && k < 200) begin @(negedge clk); k++; end
    repeat (6) @(negedge clk);
    tests++; if (wr_log.size() != 1) begin
      failed++; $display("[TB] FAIL wr1_count got %0d want 1", wr_log.size()); end
    else begin
      tests++; if (wr_log[0] !== {8'h10, 32'h12345678}) begin
        failed++; $display("[TB] FAIL wr1_data got %h want 1012345678", wr_log[0]); end
    end
    tests++; if (err_o !== 1'b0) begin
      failed++; $display("[TB] FAIL wr1_err got %b want 0", err_o); end
`ifdef OKWB_WRITE_ACK_EN
    tests++; if (out_q.size() != 1 || out_q[0] !== 16'hC010) begin
      failed++; $display("[TB] FAIL wr1_ack got size %0d want 1 word C010", out_q.size()); end
`else
    tests++; if (out_q.size() != 0) begin
      failed++; $display("[TB] FAIL wr1_no_push got %0d words want 0", out_q.size()); end
`endif
  endtask

  task automatic test_read_wrap();
    logic [15:0] exp[7];
    int k = 0;
    exp = '{16'h82FE, 16'h02FA, 16'h0000, 16'h02FD, 16'h0000, 16'h0000, 16'h0000};
    do_reset();
    in_q.push_back(16'h82FE);
    while (out_q.size() < 7 && k < 400) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    tests++; if (out_q.size() != 7) begin
      failed++; $display("[TB] FAIL rd_count got %0d want 7", out_q.size()); end
    else begin
      for (int i = 0; i < 7; i++) begin
        tests++; if (out_q[i] !== exp[i]) begin
          failed++; $display("[TB] FAIL rd_word%0d got %h want %h", i, out_q[i], exp[i]); end
      end
      tests++; if (out_cyc[0] - last_pop_cyc != 3) begin
        failed++; $display("[TB] FAIL rd_latency got %0d want 3", out_cyc[0] - last_pop_cyc); end
    end
    tests++; if (err_o !== 1'b0) begin
      failed++; $display("[TB] FAIL rd_err got %b want 0", err_o); end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    do_reset();
    in_q.push_back(16'h41FF);
    in_q.push_back(16'h1111); in_q.push_back(16'hAAAA);
    in_q.push_back(16'h2222); in_q.push_back(16'hBBBB);
    while (wr_log.size() < 2 && k < 300) begin @(negedge clk); k++; end
    repeat (6) @(negedge clk);
    tests++; if (wr_log.size() != 2) begin
      failed++; $display("[TB] FAIL b2b_count got %0d want 2", wr_log.size()); end
    else begin
      tests++; if (wr_log[0] !== {8'hFF, 32'hAAAA1111}) begin
        failed++; $display("[TB] FAIL b2b_first got %h want FFAAAA1111", wr_log[0]); end
      tests++; if (wr_log[1] !== {8'h00, 32'hBBBB2222}) begin
        failed++; $display("[TB] FAIL b2b_wrap got %h want 00BBBB2222", wr_log[1]); end
    end
`ifdef OKWB_WRITE_ACK_EN
    tests++; if (out_q.size() != 1 || out_q[0] !== 16'hC1FF) begin
      failed++; $display("[TB] FAIL b2b_ack got size %0d want 1 word C1FF", out_q.size()); end
`endif
  endtask

  task automatic test_timeout();
    logic [15:0] exp[3];
    int k = 0;
    exp = '{16'h8005, 16'hBEEF, 16'hDEAD};
    do_reset();
    ack_en = 1'b0;
    in_q.push_back(16'h8005);
    while (out_q.size() < 3 && k < 400) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    tests++; if (out_q.size() != 3) begin
      failed++; $display("[TB] FAIL tmo_count got %0d want 3", out_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        tests++; if (out_q[i] !== exp[i]) begin
          failed++; $display("[TB] FAIL tmo_word%0d got %h want %h", i, out_q[i], exp[i]); end
      end
    end
    tests++; if (stb_cycles != TMO) begin
      failed++; $display("[TB] FAIL tmo_stb_len got %0d want %0d", stb_cycles, TMO); end
    tests++; if (err_o !== 1'b1) begin
      failed++; $display("[TB] FAIL tmo_err got %b want 1", err_o); end
    ack_en = 1'b1;
  endtask

  task automatic test_illegal();
    int k = 0;
    do_reset();
    in_q.push_back(16'hC0AA); in_q.push_back(16'h8001);
    while (out_q.size() < 3 && k < 300) begin @(negedge clk); k++; end
    repeat (10) @(negedge clk);
    tests++; if (out_q.size() != 3) begin
      failed++; $display("[TB] FAIL ill_count got %0d want 3", out_q.size()); end
    else begin
      tests++; if (out_q[0] !== 16'h8001 || out_q[1] !== 16'h0003 || out_q[2] !== 16'h0000) begin
        failed++; $display("[TB] FAIL ill_words got %h %h %h want 8001 0003 0000", out_q[0], out_q[1], out_q[2]); end
    end
    tests++; if (err_o !== 1'b1) begin
      failed++; $display("[TB] FAIL ill_err got %b want 1", err_o); end
  endtask

  task automatic test_starved();
    int k = 0;
    int idle_seen = 0;
    do_reset();
    in_q.push_back(16'h4020);
    while (pop_cnt < 1 && k < 50) begin @(negedge clk); k++; end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy_o) idle_seen++;
    end
    tests++; if (pop_cnt != 1) begin
      failed++; $display("[TB] FAIL starve_pops got %0d want 1", pop_cnt); end
    tests++; if (idle_seen != 0) begin
      failed++; $display("[TB] FAIL starve_busy got %0d idle cycles want 0", idle_seen); end
    in_q.push_back(16'h9ABC); in_q.push_back(16'hDEF0);
    k = 0;
    while (wr_log.size() < 1 && k < 200) begin @(negedge clk); k++; end
    repeat (6) @(negedge clk);
    tests++; if (wr_log.size() != 1 || wr_log[0] !== {8'h20, 32'hDEF09ABC}) begin
      failed++; $display("[TB] FAIL starve_write got size %0d want 1 write 20/DEF09ABC", wr_log.size()); end
`ifdef OKWB_WRITE_ACK_EN
    tests++; if (out_q.size() != 1 || out_q[0] !== 16'hC020) begin
      failed++; $display("[TB] FAIL starve_ack got size %0d want 1 word C020", out_q.size()); end
`endif
  endtask

  task automatic test_reset_mid();
    int k = 0;
    do_reset();
    in_q.push_back(16'h4030); in_q.push_back(16'h1111);
    while (pop_cnt < 2 && k < 100) begin @(negedge clk); k++; end
    tests++; if (pop_cnt != 2) begin
      failed++; $display("[TB] FAIL mid_pops got %0d want 2", pop_cnt); end
    rst_i = 1'b1;
    @(negedge clk);
    tests++; if ({bus_stb_o, reg_stb_o, busy_o} !== 3'b000) begin
      failed++; $display("[TB] FAIL mid_strobes got %b want 000", {bus_stb_o, reg_stb_o, busy_o}); end
    rst_i = 1'b0;
    repeat (20) @(negedge clk);
    tests++; if (wr_log.size() != 0 || stb_cycles != 0) begin
      failed++; $display("[TB] FAIL mid_no_write got %0d writes %0d stb cycles want 0", wr_log.size(), stb_cycles); end
    tests++; if (err_o !== 1'b0 || busy_o !== 1'b0) begin
      failed++; $display("[TB] FAIL mid_flags got err %b busy %b want 0 0", err_o, busy_o); end
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_read_wrap();
    test_back_to_back();
    test_timeout();
    test_illegal();
    test_starved();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
